// File: rtl/seven_segment_reader.sv
// Recovers the hex digits shown on a multiplexed, active-low seven-segment display
// and presents each complete four-digit frame through a valid/ready output.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  input  logic        out_ready,
  output logic [15:0] digits_out,
  output logic        out_valid,
  output logic        pattern_err,
  output logic        overrun
);

  localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

  logic [6:0]       r_segMeta;
  logic [6:0]       r_segSync;
  logic [3:0]       r_anMeta;
  logic [3:0]       r_anSync;
  logic [10:0]      r_prevSegAn;
  logic [3:0]       r_stabCnt;
  logic [3:0]       r_seen;
  logic [3:0][3:0]  r_digits;
  logic [15:0]      r_digitsOut;
  logic             r_outValid;
  logic             r_patternErr;
  logic             r_overrun;

  logic             w_anValid;
  logic [1:0]       w_digitIdx;
  logic             w_segOk;
  logic [3:0]       w_segVal;
  logic             w_same;
  logic             w_capture;
  logic             w_frameDone;
  logic [3:0]       w_seenBase;
  logic [3:0]       w_seenNext;

  // Exactly one strobe low selects a digit; anything else is a blanked or corrupt strobe.
  always_comb begin
    w_anValid  = 1'b1;
    w_digitIdx = 2'd0;
    case (r_anSync)
      4'b1110: w_digitIdx = 2'd0;
      4'b1101: w_digitIdx = 2'd1;
      4'b1011: w_digitIdx = 2'd2;
      4'b0111: w_digitIdx = 2'd3;
      default: w_anValid  = 1'b0;
    endcase
  end

  always_comb begin
    w_segOk  = 1'b1;
    w_segVal = 4'h0;
    case (r_segSync)
      7'b1000000: w_segVal = 4'h0;
      7'b1111001: w_segVal = 4'h1;
      7'b0100100: w_segVal = 4'h2;
      7'b0110000: w_segVal = 4'h3;
      7'b0011001: w_segVal = 4'h4;
      7'b0010010: w_segVal = 4'h5;
      7'b0000010: w_segVal = 4'h6;
      7'b1011000: w_segVal = 4'h7;
      7'b0000000: w_segVal = 4'h8;
      7'b0010000: w_segVal = 4'h9;
      7'b0001000: w_segVal = 4'hA;
      7'b0000011: w_segVal = 4'hB;
      7'b1000110: w_segVal = 4'hC;
      7'b0100001: w_segVal = 4'hD;
      7'b0000110: w_segVal = 4'hE;
      7'b0001110: w_segVal = 4'hF;
      default:    w_segOk  = 1'b0;
    endcase
  end

  // Capture only on the step into saturation, so a held digit is taken once.
  assign w_same      = ({r_segSync, r_anSync} == r_prevSegAn);
  assign w_capture   = w_anValid && w_same && (r_stabCnt == STABLE_LAST);
  assign w_frameDone = (r_seen == 4'b1111);
  assign w_seenBase  = w_frameDone ? 4'b0000 : r_seen;

  always_comb begin
    w_seenNext = w_seenBase;
    if (w_capture) begin
      w_seenNext[w_digitIdx] = w_segOk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segMeta   <= '0;
      r_segSync   <= '0;
      r_anMeta    <= '0;
      r_anSync    <= '0;
      r_prevSegAn <= '0;
      r_stabCnt   <= '0;
    end else begin
      r_segMeta   <= seg_in;
      r_segSync   <= r_segMeta;
      r_anMeta    <= an_in;
      r_anSync    <= r_anMeta;
      r_prevSegAn <= {r_segSync, r_anSync};
      if (!w_same || !w_anValid) begin
        r_stabCnt <= '0;
      end else if (r_stabCnt != STABLE_MAX) begin
        r_stabCnt <= r_stabCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen       <= '0;
      r_digits     <= '0;
      r_patternErr <= 1'b0;
    end else begin
      r_seen       <= w_seenNext;
      r_patternErr <= w_capture && !w_segOk;
      if (w_capture && w_segOk) begin
        r_digits[w_digitIdx] <= w_segVal;
      end
    end
  end

  // A completed frame replaces the presented one only if it was free or is being taken now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digitsOut <= '0;
      r_outValid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_frameDone) begin
      if (!r_outValid || out_ready) begin
        r_digitsOut <= r_digits;
        r_outValid  <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign digits_out  = r_digitsOut;
  assign out_valid   = r_outValid;
  assign pattern_err = r_patternErr;
  assign overrun     = r_overrun;

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (legal range 2..15), meaning the number of consecutive identical synchronized samples required before a digit is captured.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port seg_in, input, 7, active-low segment bus; bit0 = a … bit6 = g.
REQ-005 SHALL have port an_in, input, 4, active-low digit strobe; an_in[k] low selects digit k.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts the frame.
REQ-007 SHALL have port digits_out, output, 16, captured frame; digit k is on bits [4k+3:4k].
REQ-008 SHALL have port out_valid, output, 1, frame available.
REQ-009 SHALL have port pattern_err, output, 1, one-cycle pulse on an undecodable pattern.
REQ-010 SHALL have port overrun, output, 1, sticky flag for a lost frame.

Function
REQ-011 SHALL pass seg_in and an_in through a 2-flop synchronizer before any use.
REQ-012 SHALL treat a synchronized an_in as valid only when exactly one bit is 0.
REQ-013 SHALL maintain stab_cnt, saturating at STABLE_CYCLES, under these rules:
- cleared when the synchronized {seg,an} differs from the previous cycle's value;
- cleared when the synchronized an is not valid;
- incremented otherwise.
REQ-014 SHALL raise a capture event only on the cycle stab_cnt steps from STABLE_CYCLES-1 to STABLE_CYCLES.
- Capture fires exactly once per stable period.
- Pin-to-digit-register latency is 2+STABLE_CYCLES cycles.
REQ-015 SHALL decode segment patterns (seg[6:0] order, active-low) as follows:
- 1000000=0, 1111001=1, 0100100=2, 0110000=3
- 0011001=4, 0010010=5, 0000010=6, 1011000=7
- 0000000=8, 0010000=9, 0001000=A, 0000011=B
- 1000110=C, 0100001=D, 0000110=E, 0001110=F
REQ-016 SHALL, on a capture with a decodable pattern for digit k, write the value into internal digit register k and set seen[k].
REQ-017 SHALL, on a capture with an undecodable pattern, pulse pattern_err high for 1 cycle, clear seen[k], and leave digit register k unchanged.
REQ-018 SHALL declare the frame complete in the cycle after seen becomes 4'b1111, then clear seen.
REQ-019 SHALL handle frame completion according to output state:
- out_valid=0: load digits_out and set out_valid.
- out_valid=1 with out_ready=1 in the same cycle: load the new frame; out_valid stays 1.
- out_valid=1 with out_ready=0: drop the new frame, keep digits_out unchanged, set overrun.
REQ-020 SHALL clear out_valid on out_ready=1 when no frame completes in the same cycle.
REQ-021 SHALL hold digits_out stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear overrun only by reset.
REQ-023 SHALL count re-capture of an already-seen digit within a frame as an overwrite of that digit, with no error.

Reset
REQ-024 SHALL, while rst=1, force all outputs to 0: digits_out=16'h0000, out_valid=0, pattern_err=0, overrun=0.
REQ-025 SHALL, while rst=1, clear the synchronizers, stab_cnt, seen and the digit registers.
REQ-026 SHALL, when rst asserts mid-frame, discard the partial frame; the first post-reset frame requires all 4 digits afresh.

Verification
REQ-027 SHALL cover a basic frame:
- stimulus: STABLE_CYCLES=4; an_in=1110/1101/1011/0111, 10 cycles each, seg=0-3 patterns; out_ready=0.
- response: out_valid=1, digits_out=16'h3210, and the first digit is captured 6 cycles after the pins settle.
REQ-028 SHALL cover glitch rejection:
- stimulus: a seg pattern held only 3 cycles before changing.
- response: no capture, seen unchanged.
REQ-029 SHALL cover a bad pattern:
- stimulus: seg=7'b1111111 held stable on digit 2.
- response: a single pattern_err pulse, and no frame until digit 2 is re-captured validly.
REQ-030 SHALL cover overrun:
- stimulus: two complete frames (h3210, then hABCD) with out_ready=0.
- response: digits_out=16'h3210 and overrun=1; after out_ready=1 for 1 cycle, out_valid=0.
REQ-031 SHALL cover reset and invalid strobes:
- stimulus: assert rst after 3 digits are captured, then release.
- response: all outputs 0; after reset, 1 more digit alone produces no out_valid.
- stimulus: an_in=1100 held.
- response: no capture.
